// File: rtl/axis_row_rx_buffer.sv
// axis_row_rx_buffer
// AXI-Stream slave that receives one feature-map row at a time into a two-bank
// (ping-pong) row BRAM. Each completed row is offered to the conv PE side with
// a row_ready / row_consumed handshake. Upstream is stalled while both banks
// hold unconsumed rows.
//
// Handshake semantics: a pixel transfers on a rising edge where
// s_axis_tvalid & s_axis_tready are both high. s_axis_tready is decoded from
// registered state only and never depends on s_axis_tvalid. On the read side,
// a row_consumed pulse releases the presented bank only while row_ready is
// high; otherwise the pulse is ignored.
//
// Optional feature: define RX_ROW_COUNTER_EN to add the rows_received output,
// a 16-bit count of closed rows that clears when the frame's last row is
// consumed.
module axis_row_rx_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 64,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              row_consumed,
    output logic              row_ready,
    output logic              rd_bank,
    output logic              row_is_last,
    output logic              tlast_err,
    output logic              rx_idle
`ifdef RX_ROW_COUNTER_EN
    ,
    output logic [15:0]       rows_received
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(IMG_W);

    typedef enum logic {
        S_RECV  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic             wr_bank;
    logic             rd_bank_q;
    logic [1:0]       full;
    logic [1:0]       last;
    logic             tlast_err_q;

    logic             hs;
    logic             col_end;
    logic             row_close;
    logic             consume;
    logic [1:0]       full_nxt;
    logic [1:0]       last_nxt;

    assign s_axis_tready = (state == S_RECV) & ~Reset;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign col_end       = (col == COL_LAST);
    assign row_close     = hs & (col_end | s_axis_tlast);
    assign consume       = row_consumed & full[rd_bank_q] & ~Reset;

    assign wr_en   = hs;
    assign wr_addr = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(col);
    assign wr_data = s_axis_tdata;

    assign rd_bank     = rd_bank_q;
    assign row_ready   = full[rd_bank_q] & ~Reset;
    assign row_is_last = last[rd_bank_q] & ~Reset;
    assign tlast_err   = tlast_err_q;
    assign rx_idle     = Reset | (~full[0] & ~full[1] & (col == '0));

    // Next bank flags: release the consumed bank, then mark the closed bank.
    // A close never targets a bank that is full, so the order cannot collide.
    always_comb begin
        full_nxt = full;
        last_nxt = last;
        if (consume) begin
            full_nxt[rd_bank_q] = 1'b0;
            last_nxt[rd_bank_q] = 1'b0;
        end
        if (row_close) begin
            full_nxt[wr_bank] = 1'b1;
            last_nxt[wr_bank] = s_axis_tlast;
        end
    end

    // Column counter, bank pointers, bank flags and the sticky early-tlast flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            col         <= '0;
            wr_bank     <= 1'b0;
            rd_bank_q   <= 1'b0;
            full        <= 2'b00;
            last        <= 2'b00;
            tlast_err_q <= 1'b0;
        end else begin
            if (hs) begin
                if (row_close) begin
                    col     <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    col <= col + 1'b1;
                end
            end
            full <= full_nxt;
            last <= last_nxt;
            if (consume) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (row_close && !col_end) begin
                tlast_err_q <= 1'b1;
            end
        end
    end

    // Write FSM: stall after a close if the bank we move into is still full
    // (looking at next-state flags so a same-cycle consume avoids a bubble).
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_RECV;
        end else begin
            case (state)
                S_RECV: begin
                    if (row_close && full_nxt[~wr_bank]) begin
                        state <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (!full_nxt[wr_bank]) begin
                        state <= S_RECV;
                    end
                end
                default: state <= S_RECV;
            endcase
        end
    end

`ifdef RX_ROW_COUNTER_EN
    // Closed-row counter; consuming the frame's last row restarts the count.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rows_received <= 16'd0;
        end else if (consume && last[rd_bank_q]) begin
            rows_received <= row_close ? 16'd1 : 16'd0;
        end else if (row_close) begin
            rows_received <= rows_received + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_row_rx_buffer.sv
// Directed testbench for axis_row_rx_buffer. BRAM writes are checked against a
// scoreboard queue filled by the pixel driver from a small bench-side model of
// the column counter and write bank.
module tb_axis_row_rx_buffer;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 64;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              Reset;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              row_consumed;
    logic              row_ready;
    logic              rd_bank;
    logic              row_is_last;
    logic              tlast_err;
    logic              rx_idle;
`ifdef RX_ROW_COUNTER_EN
    logic [15:0]       rows_received;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int m_col     = 0;
    int m_wr_bank = 0;

    axis_row_rx_buffer #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .row_consumed (row_consumed),
        .row_ready    (row_ready),
        .rd_bank      (rd_bank),
        .row_is_last  (row_is_last),
        .tlast_err    (tlast_err),
        .rx_idle      (rx_idle)
`ifdef RX_ROW_COUNTER_EN
        ,
        .rows_received(rows_received)
`endif
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one pixel, hold it until accepted, push the expected BRAM write.
    // Called before the rising edge; returns at the following falling edge
    // with tvalid still asserted.
    task automatic send(input logic [DATA_W-1:0] data, input logic last_flag);
        int waits;
        logic [ADDR_W-1:0] addr;
        s_axis_tdata  = data;
        s_axis_tlast  = last_flag;
        s_axis_tvalid = 1'b1;
        waits = 0;
        #1;
        while (s_axis_tready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            addr = ADDR_W'(m_wr_bank * IMG_W + m_col);
            exp_q.push_back({addr, data});
            if (m_col == IMG_W - 1 || last_flag) begin
                m_col     = 0;
                m_wr_bank = 1 - m_wr_bank;
            end else begin
                m_col++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse_consume();
        row_consumed = 1'b1;
        @(negedge clk);
        row_consumed = 1'b0;
        #1;
    endtask

    // Scoreboard: every observed BRAM write must match the oldest expectation.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        #4;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {9'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("bram_write", {9'd0, wr_addr, wr_data}, {9'd0, e});
            end
        end
    end

    initial begin
        Reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        row_consumed  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_row_ready", 32'(row_ready), 32'd0);
        check("rst_row_is_last", 32'(row_is_last), 32'd0);
        check("rst_rx_idle", 32'(rx_idle), 32'd1);
        Reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);
        check("post_rst_tlast_err", 32'(tlast_err), 32'd0);

        // Row 0 into bank 0, back-to-back.
        for (int i = 0; i < IMG_W - 1; i++) send(DATA_W'(i), 1'b0);
        check("a_row_ready_before_close", 32'(row_ready), 32'd0);
        send(DATA_W'(IMG_W - 1), 1'b0);
        idle_inputs();
        #1;
        check("a_row_ready", 32'(row_ready), 32'd1);
        check("a_rd_bank", 32'(rd_bank), 32'd0);
        check("a_row_is_last", 32'(row_is_last), 32'd0);
        check("a_rx_idle", 32'(rx_idle), 32'd0);
        check("a_tready", 32'(s_axis_tready), 32'd1);
`ifdef RX_ROW_COUNTER_EN
        check("a_rows_received", 32'(rows_received), 32'd1);
`endif

        // Row 1 into bank 1; both banks now full, so upstream is stalled.
        for (int i = 0; i < IMG_W; i++) send(DATA_W'(100 + i), 1'b0);
        #1;
        check("b_stall_tready", 32'(s_axis_tready), 32'd0);
        check("b_rd_bank", 32'(rd_bank), 32'd0);

        // Consume while a pixel is offered: it lands in the freed bank next cycle.
        s_axis_tdata  = DATA_W'(200);
        s_axis_tvalid = 1'b1;
        row_consumed  = 1'b1;
        #1;
        check("b_sim_tready", 32'(s_axis_tready), 32'd0);
        check("b_sim_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        row_consumed = 1'b0;
        #1;
        check("b_resume_tready", 32'(s_axis_tready), 32'd1);
        check("b_rd_bank_toggle", 32'(rd_bank), 32'd1);
        check("b_row_ready_bank1", 32'(row_ready), 32'd1);
        for (int i = 0; i < IMG_W; i++) send(DATA_W'(200 + i), 1'b0);
        idle_inputs();
        #1;
        check("b_stall2_tready", 32'(s_axis_tready), 32'd0);
        check("b_rd_bank_once", 32'(rd_bank), 32'd1);
        pulse_consume();
        check("b_rd_bank_back", 32'(rd_bank), 32'd0);
        check("b_tready_after", 32'(s_axis_tready), 32'd1);
        check("b_row_ready_row3", 32'(row_ready), 32'd1);
        pulse_consume();
        check("b_drained_ready", 32'(row_ready), 32'd0);
        check("b_drained_idle", 32'(rx_idle), 32'd1);

        // Last row of the frame with tlast on the final pixel (bank 1).
        for (int i = 0; i < IMG_W; i++) send(DATA_W'(300 + i), (i == IMG_W - 1));
        idle_inputs();
        #1;
        check("c_row_ready", 32'(row_ready), 32'd1);
        check("c_row_is_last", 32'(row_is_last), 32'd1);
        check("c_tlast_err", 32'(tlast_err), 32'd0);
        check("c_rd_bank", 32'(rd_bank), 32'd1);
        pulse_consume();
        check("c_ready_clear", 32'(row_ready), 32'd0);
        check("c_last_clear", 32'(row_is_last), 32'd0);
        check("c_rx_idle", 32'(rx_idle), 32'd1);

        // Early tlast on pixel 10 (bank 0), then next row starts in bank 1.
        for (int i = 0; i <= 10; i++) send(DATA_W'(400 + i), (i == 10));
        for (int i = 0; i < 5; i++) send(DATA_W'($urandom_range(0, 16'hFFFF)), 1'b0);
        idle_inputs();
        #1;
        check("d_tlast_err", 32'(tlast_err), 32'd1);
        check("d_row_ready", 32'(row_ready), 32'd1);
        check("d_row_is_last", 32'(row_is_last), 32'd1);
        check("d_rd_bank", 32'(rd_bank), 32'd0);
        check("d_rx_idle", 32'(rx_idle), 32'd0);

        // Grow the partial row to col 30, then reset mid-row.
        for (int i = 5; i < 30; i++) send(DATA_W'(500 + i), 1'b0);
        idle_inputs();
        #1;
        check("e_tlast_err_sticky", 32'(tlast_err), 32'd1);
        Reset = 1'b1;
        #1;
        check("e_rst_tready", 32'(s_axis_tready), 32'd0);
        check("e_rst_row_ready", 32'(row_ready), 32'd0);
        check("e_rst_rx_idle", 32'(rx_idle), 32'd1);
        @(negedge clk);
        Reset = 1'b0;
        m_col     = 0;
        m_wr_bank = 0;
        #1;
        check("e_post_idle", 32'(rx_idle), 32'd1);
        check("e_post_row_ready", 32'(row_ready), 32'd0);
        check("e_post_tlast_err", 32'(tlast_err), 32'd0);
        check("e_post_tready", 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < 4; i++) send(DATA_W'(600 + i), 1'b0);
        idle_inputs();
        repeat (2) @(negedge clk);
        #5;
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_row_rx_buffer.md
Name: axis_row_rx_buffer

Overview:
- AXI-Stream slave receiver. Accepts input feature-map pixels row by row and writes them into a two-bank (ping-pong) row BRAM.
- Presents completed rows to the conv PE/buffer control side with a ready/consumed handshake.
- Counterpart to the PE output streamer: this block is the receive end feeding the conv datapath, while the streamer drives m_axis toward the next stage.
- Back-pressures the upstream master whenever both banks hold unconsumed rows.

Parameters:
- DATA_W, 16, pixel width in bits.
- IMG_W, 64, pixels per row (must be >= 2).
- ADDR_W, 7, BRAM address width; must satisfy 2^ADDR_W >= 2*IMG_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  input pixel.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tlast  in  1  last pixel of last row of the frame.
- s_axis_tready  out  1  receiver can accept.
- wr_en  out  1  row BRAM port-A write enable.
- wr_addr  out  ADDR_W  write address = wr_bank*IMG_W + col.
- wr_data  out  DATA_W  write data = s_axis_tdata.
- row_consumed  in  1  one-cycle pulse from the PE side: presented row fully read.
- row_ready  out  1  bank rd_bank holds a complete row.
- rd_bank  out  1  bank the consumer must read (read base = rd_bank*IMG_W).
- row_is_last  out  1  presented row is the frame's last row.
- tlast_err  out  1  sticky: tlast arrived before col == IMG_W-1.
- rx_idle  out  1  both banks empty and col == 0.

Behaviour:
- Registered state:
  - col counter (0..IMG_W-1).
  - wr_bank and rd_bank, 1 bit each.
  - full[1:0] and last[1:0] flags.
  - tlast_err.
  - Write FSM with states S_RECV and S_STALL.
- Reset (synchronous, active-high):
  - Registers clear: col=0, wr_bank=0, rd_bank=0, full=0, last=0, tlast_err=0, FSM=S_RECV.
  - Outputs while Reset is high: s_axis_tready=0, wr_en=0, row_ready=0, row_is_last=0, rx_idle=1.
  - Reset mid-row discards the partial row. Reset with full banks discards both rows.
- s_axis_tready:
  - 1 only in S_RECV with Reset low.
  - Decoded from registered state only; there is no combinational path from tvalid.
- Handshake (hs) = tvalid & tready. On hs:
  - wr_en=1, combinational, same cycle (zero latency).
  - wr_addr = wr_bank*IMG_W + col.
- On hs with col < IMG_W-1 and tlast=0: col increments.
- Row close happens on hs with col == IMG_W-1, or on hs with tlast=1 at any col:
  - full[wr_bank]<=1, last[wr_bank]<=tlast.
  - col<=0, wr_bank toggles.
- Early tlast (col < IMG_W-1): row closes as above and tlast_err<=1. tlast_err stays set until Reset. Unwritten slots are don't-care.
- FSM transitions:
  - S_RECV -> S_STALL when a row closes and the next bank (the new wr_bank) is still full.
  - S_STALL -> S_RECV when full[wr_bank] clears.
- Read side:
  - row_ready = full[rd_bank]; row_is_last = last[rd_bank].
  - row_consumed with row_ready=1: full[rd_bank]<=0, last[rd_bank]<=0, rd_bank toggles.
  - row_consumed with row_ready=0 is ignored.
- Simultaneous row close and consume:
  - They always target different banks, or the same bank only when that bank was empty. Both updates take effect in the same cycle.
  - A consume that frees the next write bank in the same cycle as a close keeps the FSM in S_RECV, so tready stays 1 with no bubble.
- Throughput: one pixel per cycle sustained while the consumer keeps up. After the first row there is at most one row of buffering slack.
- row_ready rises one cycle after the closing handshake (registered).
- rx_idle = ~full[0] & ~full[1] & (col==0).

Optional Feature:
- Macro: RX_ROW_COUNTER_EN.
- When defined, adds output rows_received[15:0]:
  - Increments on each row close, wrapping at 65535.
  - Clears to 0 on Reset.
  - Clears to 0 in the cycle a row with row_is_last=1 is consumed. If a close coincides with that consume, the result is 1.
- When undefined, the port is absent and there is no counter logic.

Test Plan:
- Reset, stream IMG_W=64 pixels 0..63 with tvalid held high and tlast=0 -> wr_en high for 64 cycles, wr_addr 0..63; row_ready=1 one cycle after pixel 63, rd_bank=0, row_is_last=0.
- Stream 3 rows without asserting row_consumed -> tready drops after the 128th handshake; pulse row_consumed -> tready=1 next cycle; the third row is written at addresses 0..63.
- Stream the last row with tlast on pixel 63 -> row_is_last=1, tlast_err=0; row_consumed -> row_ready=0, rx_idle=1.
- tlast on pixel 10 -> row closes after 11 writes, tlast_err=1 and sticky; the next row writes to bank 1 starting at addr 64.
- Both banks full; in the same cycle row_consumed pulses and upstream presents tvalid -> tready=1 the following cycle, the pixel is written to the freed bank, and rd_bank toggles exactly once.
- Assert Reset at col=30 -> next cycle col=0, full=0, tready=0 during Reset; the following row restarts at addr 0.
